// File: rtl/pc_ctrl_pkg.sv
// Shared types and constants for the fetch-stage PC controller.
package pc_ctrl_pkg;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_REFILL = 1'b1
  } fetch_state_e;

  localparam logic [31:0] PC_INC           = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Fetch addresses are word aligned; the low two bits of any target are dropped.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  function automatic logic [31:0] line_base(input logic [31:0] addr, input logic [31:0] line_mask);
    return addr & ~line_mask;
  endfunction

endpackage

// File: rtl/pc_fetch_controller_sat_counter16.sv
// 16-bit saturating event counter with increment enable and asynchronous reset.
module sat_counter16 (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_inc,
  output logic [15:0] o_count
);

  logic [15:0] r_count;

  // Count enabled events, sticking at all-ones instead of wrapping.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= 16'h0000;
    end else if (i_inc && (r_count != 16'hFFFF)) begin
      r_count <= r_count + 16'd1;
    end else begin
      r_count <= r_count;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/pc_fetch_controller.sv
// Fetch-stage PC sequencer: sequential/branch/jump next-PC selection, stall hold,
// and I-cache refill handshake with replay and deferred redirect.
module pc_fetch_controller
  import pc_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          LINE_BYTES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hit,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        refill_done,
  output logic [31:0] pc,
  output logic        fetch_valid,
  output logic        refill_req,
  output logic [31:0] refill_addr,
  output logic [15:0] miss_count
);

  localparam logic [31:0] LINE_MASK = 32'(LINE_BYTES - 1);

  fetch_state_e r_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_pend_pc;
  logic         r_pend_valid;
  logic         r_refill_req;
  logic [31:0]  r_refill_addr;

  logic         w_redir;
  logic [31:0]  w_target;
  logic         w_miss_start;

  // Branch is the older instruction, so it wins over a same-cycle jump.
  always_comb begin
    w_redir = branch_taken | jump;
    if (branch_taken) begin
      w_target = word_align(branch_target);
    end else begin
      w_target = word_align(jump_target);
    end
  end

  assign w_miss_start = (r_state == ST_RUN) & ~w_redir & ~hit;
  assign fetch_valid  = ~rst & (r_state == ST_RUN) & hit & ~w_redir & ~stall;

  // Owned state machine for the PC register and refill handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_RUN;
      r_pc          <= RESET_PC;
      r_pend_pc     <= 32'h0000_0000;
      r_pend_valid  <= 1'b0;
      r_refill_req  <= 1'b0;
      r_refill_addr <= 32'h0000_0000;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_redir) begin
            r_pc <= w_target;
          end else if (!hit) begin
            r_state       <= ST_REFILL;
            r_refill_req  <= 1'b1;
            r_refill_addr <= line_base(r_pc, LINE_MASK);
          end else if (!stall) begin
            r_pc <= r_pc + PC_INC;
          end else begin
            r_pc <= r_pc;
          end
        end
        ST_REFILL: begin
          // Refill always completes; redirects seen meanwhile are applied on return.
          if (refill_done) begin
            r_state      <= ST_RUN;
            r_refill_req <= 1'b0;
            r_pend_valid <= 1'b0;
            if (w_redir) begin
              r_pc <= w_target;
            end else if (r_pend_valid) begin
              r_pc <= r_pend_pc;
            end else begin
              r_pc <= r_pc;
            end
          end else if (w_redir) begin
            r_pend_pc    <= w_target;
            r_pend_valid <= 1'b1;
          end else begin
            r_pend_valid <= r_pend_valid;
          end
        end
        default: begin
          r_state      <= ST_RUN;
          r_refill_req <= 1'b0;
          r_pend_valid <= 1'b0;
        end
      endcase
    end
  end

  sat_counter16 u_miss_counter (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_inc   (w_miss_start),
    .o_count (miss_count)
  );

  assign pc          = r_pc;
  assign refill_req  = r_refill_req;
  assign refill_addr = r_refill_addr;

endmodule

// File: tb/tb_pc_fetch_controller.sv
// Self-checking bench: directed scenarios plus random traffic against a behavioural model.
module tb_pc_fetch_controller;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          LINE   = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        t_hit = 1'b0;
  logic        t_stall = 1'b0;
  logic        t_bt = 1'b0;
  logic [31:0] t_btgt = 32'h0;
  logic        t_jp = 1'b0;
  logic [31:0] t_jtgt = 32'h0;
  logic        t_rd = 1'b0;
  logic [31:0] pc;
  logic        fetch_valid;
  logic        refill_req;
  logic [31:0] refill_addr;
  logic [15:0] miss_count;

  logic        sat_rst = 1'b1;
  logic        sat_inc = 1'b0;
  logic [15:0] sat_count;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  bit          m_refill;
  logic [31:0] m_pc;
  bit          m_pend_ok;
  logic [31:0] m_pend_pc;
  bit          m_req;
  logic [31:0] m_addr;
  int          m_misses;

  always #5 clk = ~clk;

  pc_fetch_controller #(.RESET_PC(RST_PC), .LINE_BYTES(LINE)) dut (
    .clk(clk), .rst(rst), .hit(t_hit), .stall(t_stall),
    .branch_taken(t_bt), .branch_target(t_btgt), .jump(t_jp), .jump_target(t_jtgt),
    .refill_done(t_rd), .pc(pc), .fetch_valid(fetch_valid), .refill_req(refill_req),
    .refill_addr(refill_addr), .miss_count(miss_count)
  );

  sat_counter16 u_sat (.i_clk(clk), .i_rst(sat_rst), .i_inc(sat_inc), .o_count(sat_count));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_refill = 0; m_pc = RST_PC; m_pend_ok = 0; m_pend_pc = 32'h0;
    m_req = 0; m_addr = 32'h0; m_misses = 0;
  endtask

  function automatic logic [31:0] model_target();
    logic [31:0] raw;
    raw = t_bt ? t_btgt : t_jtgt;
    return raw - (raw % 32'd4);
  endfunction

  function automatic bit model_fv();
    return !m_refill && t_hit && !(t_bt || t_jp) && !t_stall;
  endfunction

  task automatic model_clock();
    bit redirect;
    logic [31:0] tgt;
    redirect = t_bt || t_jp;
    tgt = model_target();
    if (!m_refill) begin
      if (redirect) m_pc = tgt;
      else if (!t_hit) begin
        m_refill = 1; m_req = 1;
        m_addr = m_pc - (m_pc % LINE);
        m_misses++;
      end else if (!t_stall) m_pc = m_pc + 32'd4;
    end else if (t_rd) begin
      if (redirect) m_pc = tgt;
      else if (m_pend_ok) m_pc = m_pend_pc;
      m_refill = 0; m_req = 0; m_pend_ok = 0;
    end else if (redirect) begin
      m_pend_pc = tgt; m_pend_ok = 1;
    end
  endtask

  function automatic logic [15:0] model_misses();
    return (m_misses > 65535) ? 16'hFFFF : 16'(m_misses);
  endfunction

  // One clock: check combinational fetch_valid, advance, check registered outputs.
  task automatic tick();
    #1;
    check("fetch_valid", 32'(fetch_valid), 32'(model_fv()));
    @(posedge clk);
    model_clock();
    #1;
    check("pc", pc, m_pc);
    check("refill_req", 32'(refill_req), 32'(m_req));
    check("refill_addr", refill_addr, m_addr);
    check("miss_count", 32'(miss_count), 32'(model_misses()));
  endtask

  task automatic set_in(input logic h, input logic s, input logic b, input logic [31:0] bt,
                        input logic j, input logic [31:0] jt, input logic r);
    t_hit = h; t_stall = s; t_bt = b; t_btgt = bt; t_jp = j; t_jtgt = jt; t_rd = r;
  endtask

  initial begin
    model_reset();
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_pc", pc, RST_PC);
    check("rst_req", 32'(refill_req), 32'd0);
    check("rst_addr", refill_addr, 32'd0);
    check("rst_miss", 32'(miss_count), 32'd0);
    check("rst_fv", 32'(fetch_valid), 32'd0);
    rst = 1'b0; sat_rst = 1'b0;

    // Sequential fetch
    set_in(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    repeat (4) tick();
    check("seq_pc", pc, 32'd16);

    // Asynchronous reset mid-run
    #2 rst = 1'b1;
    #1;
    check("async_rst_pc", pc, RST_PC);
    check("async_rst_fv", 32'(fetch_valid), 32'd0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;

    // Branch beats jump, target low bits dropped
    set_in(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h20, 1'b0); tick();
    set_in(1'b1, 1'b0, 1'b1, 32'h103, 1'b1, 32'h400, 1'b0); tick();
    check("branch_wins", pc, 32'h100);

    // Miss at 0x44, refill done 3 cycles later, replay
    set_in(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h44, 1'b0); tick();
    set_in(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0); tick();
    check("miss_addr", refill_addr, 32'h40);
    check("miss_cnt1", 32'(miss_count), 32'd1);
    repeat (2) tick();
    set_in(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1); tick();
    check("replay_pc", pc, 32'h44);
    check("replay_req", 32'(refill_req), 32'd0);
    set_in(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0); tick();

    // Redirects during refill: last one wins; same-cycle redirect beats pending
    set_in(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0); tick();
    set_in(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h200, 1'b0); tick();
    set_in(1'b0, 1'b0, 1'b1, 32'h300, 1'b0, 32'h0, 1'b0); tick();
    set_in(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1); tick();
    check("pend_pc", pc, 32'h300);
    set_in(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0); tick();
    set_in(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h600, 1'b0); tick();
    set_in(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h500, 1'b1); tick();
    check("done_redir_pc", pc, 32'h500);

    // Stall hold and release
    set_in(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h80, 1'b0); tick();
    set_in(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    repeat (3) tick();
    check("stall_hold", pc, 32'h80);
    set_in(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0); tick();
    check("stall_release", pc, 32'h84);

    // PC wrap
    set_in(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFF, 1'b0); tick();
    set_in(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0); tick();
    check("pc_wrap", pc, 32'h0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      t_hit   = ($urandom_range(0, 3) != 0);
      t_stall = ($urandom_range(0, 4) == 0);
      t_bt    = ($urandom_range(0, 5) == 0);
      t_jp    = ($urandom_range(0, 5) == 0);
      t_btgt  = $urandom;
      t_jtgt  = $urandom;
      t_rd    = m_refill ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
      tick();
    end

    // Counter saturation
    #2 sat_inc = 1'b1;
    repeat (65534) @(posedge clk);
    #1 check("sat_fffe", 32'(sat_count), 32'h0000_FFFE);
    @(posedge clk);
    #1 check("sat_ffff", 32'(sat_count), 32'h0000_FFFF);
    repeat (3) @(posedge clk);
    #1 check("sat_hold", 32'(sat_count), 32'h0000_FFFF);
    sat_inc = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
